pipe_hazard_ctrl: RTL and testbench

// - Central freeze/flush sequencer for the 5-stage ARM pipeline. Drives freeze/flush of IF/ID and ID/EXE stage regs and PC write-hold.
// - Merges ID data-hazard, EXE branch-taken and MEM-stage SRAM wait into one consistent control set.
// - Watchdog flags a hung memory access and parks the pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: freeze/flush sequencer for the 5-stage pipeline with    |
// | memory-wait watchdog. Optional perf counters under PIPE_PERF_CNT_EN.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             be_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_WDOG_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_flush;
  logic [CNT_W-1:0] r_wdog;
  logic             w_mem_stall;
  logic             w_flush_eff;
  logic             w_error;

  assign w_error     = (r_state == ERROR);
  assign w_mem_stall = ((r_state == MEM_WAIT) |
                        ((r_state == RUN) & mem_req & ~mem_ready)) & ~mem_ready;
  assign w_flush_eff = branch_taken | r_pend_flush;
  assign mem_err     = w_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pend_flush <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A branch resolved while stalled is remembered until the pipe can move.
      if (w_mem_stall && branch_taken)
        r_pend_flush <= 1'b1;
      else if (!w_mem_stall && !w_error)
        r_pend_flush <= 1'b0;
      if (r_state == RUN)
        r_wdog <= '0;
      else if (r_state == MEM_WAIT && r_wdog != '1)
        r_wdog <= r_wdog + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (mem_req && !mem_ready) w_state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (mem_ready)
          w_state_nxt = RUN;
        else if (r_wdog == c_WDOG_LAST)
          w_state_nxt = ERROR;
      end
      ERROR:    w_state_nxt = ERROR;
      default:  w_state_nxt = RUN;
    endcase
  end

  // Priority: memory stall / error, then flush, then ID hazard bubble.
  always_comb begin
    pc_freeze = 1'b0;
    if_freeze = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    be_freeze = 1'b0;
    if (w_mem_stall || w_error) begin
      pc_freeze = 1'b1;
      if_freeze = 1'b1;
      be_freeze = 1'b1;
    end else if (w_flush_eff) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      pc_freeze = 1'b1;
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_freeze && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (if_flush && r_flush_cnt != '1)  r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if_freeze;
  logic             if_flush;
  logic             id_flush;
  logic             be_freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Output vector order: {pc_freeze, if_freeze, if_flush, id_flush, be_freeze, mem_err}
  localparam logic [5:0] c_IDLE  = 6'b000000;
  localparam logic [5:0] c_HAZ   = 6'b110100;
  localparam logic [5:0] c_FLUSH = 6'b001100;
  localparam logic [5:0] c_STALL = 6'b110010;
  localparam logic [5:0] c_ERR   = 6'b110011;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_EXP_STALL = 5;
  localparam logic [CNT_W-1:0] c_EXP_FLUSH = 2;
`else
  localparam logic [CNT_W-1:0] c_EXP_STALL = 0;
  localparam logic [CNT_W-1:0] c_EXP_FLUSH = 0;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_freeze    (pc_freeze),
    .if_freeze    (if_freeze),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .be_freeze    (be_freeze),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic h, input logic b, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    hazard       = h;
    branch_taken = b;
    mem_req      = req;
    mem_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_freeze, if_freeze, if_flush, id_flush, be_freeze, mem_err};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                         input logic [CNT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    hazard       = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("reset_outputs", c_IDLE);
    chk_cnt("reset_stall_cnt", stall_cnt, '0);
    chk_cnt("reset_flush_cnt", flush_cnt, '0);

    // ID hazard for two cycles, then idle
    cyc(1, 0, 0, 0); chk_out("hazard_c1", c_HAZ);
    cyc(1, 0, 0, 0); chk_out("hazard_c2", c_HAZ);
    cyc(0, 0, 0, 0); chk_out("hazard_release", c_IDLE);

    // Branch overrides a wrong-path hazard
    cyc(1, 1, 0, 0); chk_out("branch_over_hazard", c_FLUSH);
    cyc(1, 0, 0, 0); chk_out("hazard_c3", c_HAZ);
    cyc(1, 0, 0, 0); chk_out("hazard_c4", c_HAZ);
    cyc(1, 0, 0, 0); chk_out("hazard_c5", c_HAZ);
    cyc(0, 1, 0, 0); chk_out("branch_only", c_FLUSH);
    cyc(0, 0, 0, 0); chk_out("idle_after_branch", c_IDLE);
    // 5 stalled cycles and 2 flush cycles so far
    chk_cnt("perf_stall_cnt", stall_cnt, c_EXP_STALL);
    chk_cnt("perf_flush_cnt", flush_cnt, c_EXP_FLUSH);

    // Memory wait with a branch arriving mid-stall; flush deferred to release
    cyc(0, 0, 1, 0); chk_out("mem_stall_c1", c_STALL);
    cyc(0, 1, 1, 0); chk_out("mem_stall_c2_branch", c_STALL);
    cyc(1, 0, 1, 0); chk_out("mem_stall_c3_hazard", c_STALL);
    cyc(0, 0, 1, 1); chk_out("mem_release_pend_flush", c_FLUSH);
    cyc(0, 0, 0, 0); chk_out("run_after_mem", c_IDLE);

    // Ready in the same cycle as the request: no stall
    cyc(0, 0, 1, 1); chk_out("mem_ready_same_cycle", c_IDLE);
    cyc(0, 0, 0, 0); chk_out("idle_after_fast_mem", c_IDLE);

    // Watchdog: one RUN stall cycle plus MEM_TIMEOUT=4 MEM_WAIT cycles, then ERROR
    cyc(0, 0, 1, 0); chk_out("wdog_c1", c_STALL);
    cyc(0, 0, 1, 0); chk_out("wdog_c2", c_STALL);
    cyc(0, 0, 1, 0); chk_out("wdog_c3", c_STALL);
    cyc(0, 0, 1, 0); chk_out("wdog_c4", c_STALL);
    cyc(0, 0, 1, 0); chk_out("wdog_c5_last_wait", c_STALL);
    cyc(0, 0, 1, 0); chk_out("wdog_error", c_ERR);
    cyc(0, 0, 1, 1); chk_out("error_ignores_ready", c_ERR);
    cyc(1, 1, 0, 0); chk_out("error_ignores_branch", c_ERR);
    cyc(0, 0, 0, 0); chk_out("error_sticky", c_ERR);

    // Reset leaves ERROR
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("reset_from_error", c_IDLE);
    chk_cnt("reset2_stall_cnt", stall_cnt, '0);
    chk_cnt("reset2_flush_cnt", flush_cnt, '0);
    cyc(1, 0, 0, 0); chk_out("hazard_after_reset", c_HAZ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
